// File: rtl/gate16_resp_checker.sv
// Self-checking response monitor for the 16-bit NOT/AND/OR/XOR gate library.
// Accepts operand/observation vectors over valid/ready and accumulates run statistics.
module gate16_resp_checker #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned EXP_VECTORS = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [0:WIDTH-1]   a_in,
    input  logic [0:WIDTH-1]   b_in,
    input  logic [0:WIDTH-1]   y_in,
    input  logic               valid,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   vec_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   first_fail_idx,
    output logic [0:WIDTH-1]   first_fail_y,
    output logic [0:WIDTH-1]   first_fail_exp
);

    localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LP_LAST    = CNT_W'(EXP_VECTORS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_op, w_op_nxt;
    logic [CNT_W-1:0]   r_vec, w_vec_nxt;
    logic [CNT_W-1:0]   r_err, w_err_nxt;
    logic [CNT_W-1:0]   r_ff_idx, w_ff_idx_nxt;
    logic [0:WIDTH-1]   r_ff_y, w_ff_y_nxt;
    logic [0:WIDTH-1]   r_ff_exp, w_ff_exp_nxt;
    logic               r_ready, r_busy, r_done, r_pass;
    logic               w_ready_nxt, w_busy_nxt, w_done_nxt, w_pass_nxt;
    logic [0:WIDTH-1]   w_expected;
    logic               w_accept;

    assign w_accept = valid & r_ready;

    // Reference gate output for the op latched at run start.
    always_comb begin
        w_expected = '0;
        unique case (r_op)
            2'b00: w_expected = ~a_in;
            2'b01: w_expected = a_in & b_in;
            2'b10: w_expected = a_in | b_in;
            2'b11: w_expected = a_in ^ b_in;
            default: w_expected = '0;
        endcase
    end

    // Next-state, statistics update and registered-output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_vec_nxt    = r_vec;
        w_err_nxt    = r_err;
        w_ff_idx_nxt = r_ff_idx;
        w_ff_y_nxt   = r_ff_y;
        w_ff_exp_nxt = r_ff_exp;

        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt  = S_RUN;
                    w_op_nxt     = op;
                    w_vec_nxt    = '0;
                    w_err_nxt    = '0;
                    w_ff_idx_nxt = '0;
                    w_ff_y_nxt   = '0;
                    w_ff_exp_nxt = '0;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    w_vec_nxt = r_vec + CNT_W'(1);
                    // Case inequality so X/Z on the observed output is a mismatch.
                    if (y_in !== w_expected) begin
                        if (r_err != LP_CNT_MAX) begin
                            w_err_nxt = r_err + CNT_W'(1);
                        end
                        if (r_err == '0) begin
                            w_ff_idx_nxt = r_vec;
                            w_ff_y_nxt   = y_in;
                            w_ff_exp_nxt = w_expected;
                        end
                    end
                    if (r_vec == LP_LAST) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_ready_nxt = (w_state_nxt == S_RUN);
        w_busy_nxt  = (w_state_nxt == S_RUN);
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_pass_nxt  = (w_state_nxt == S_DONE) && (w_err_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_vec    <= '0;
            r_err    <= '0;
            r_ff_idx <= '0;
            r_ff_y   <= '0;
            r_ff_exp <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_vec    <= w_vec_nxt;
            r_err    <= w_err_nxt;
            r_ff_idx <= w_ff_idx_nxt;
            r_ff_y   <= w_ff_y_nxt;
            r_ff_exp <= w_ff_exp_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_pass   <= w_pass_nxt;
        end
    end

    assign ready          = r_ready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign vec_count      = r_vec;
    assign err_count      = r_err;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_y   = r_ff_y;
    assign first_fail_exp = r_ff_exp;

endmodule

// File: tb/tb_gate16_resp_checker.sv
// Bench for gate16_resp_checker: directed run sequence with randomized vectors,
// checked against a truth-table reference model of the accepted-vector history.
module tb_gate16_resp_checker;

    localparam int unsigned EXP   = 17;
    localparam int unsigned S_EXP = 15;

    logic        clk;
    logic        rst_n;
    logic        start, s_start;
    logic [1:0]  op;
    logic [15:0] a_in, b_in, y_in;
    logic        valid, s_valid;

    logic        ready, busy, done, pass;
    logic [7:0]  vec_count, err_count, first_fail_idx;
    logic [15:0] first_fail_y, first_fail_exp;

    logic        s_ready, s_busy, s_done, s_pass;
    logic [3:0]  s_vec_count, s_err_count, s_first_fail_idx;
    logic [15:0] s_first_fail_y, s_first_fail_exp;

    gate16_resp_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in), .y_in(y_in), .valid(valid),
        .ready(ready), .busy(busy), .done(done), .pass(pass),
        .vec_count(vec_count), .err_count(err_count),
        .first_fail_idx(first_fail_idx), .first_fail_y(first_fail_y),
        .first_fail_exp(first_fail_exp)
    );

    gate16_resp_checker #(.WIDTH(16), .CNT_W(4), .EXP_VECTORS(S_EXP)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .op(op),
        .a_in(a_in), .b_in(b_in), .y_in(y_in), .valid(s_valid),
        .ready(s_ready), .busy(s_busy), .done(s_done), .pass(s_pass),
        .vec_count(s_vec_count), .err_count(s_err_count),
        .first_fail_idx(s_first_fail_idx), .first_fail_y(s_first_fail_y),
        .first_fail_exp(s_first_fail_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;

    vec_t       acc[$];
    logic [1:0] m_op;
    int         n_checks;
    int         n_fail;

    // Gate output from a per-bit truth table indexed by {a,b}.
    function automatic logic [15:0] ref_gate(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  tt;
        case (o)
            2'd0:    tt = 4'b0011;
            2'd1:    tt = 4'b1000;
            2'd2:    tt = 4'b1110;
            default: tt = 4'b0110;
        endcase
        for (int i = 0; i < 16; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_eval(input int cap, output int vec, output int err, output int idx,
                              output logic [15:0] fy, output logic [15:0] fe);
        logic [15:0] e;
        int mism;
        vec = acc.size(); mism = 0; idx = 0; fy = '0; fe = '0;
        for (int i = 0; i < acc.size(); i++) begin
            e = ref_gate(m_op, acc[i].a, acc[i].b);
            if (acc[i].y !== e) begin
                if (mism == 0) begin
                    idx = i; fy = acc[i].y; fe = e;
                end
                mism++;
            end
        end
        err = (mism > cap) ? cap : mism;
    endtask

    task automatic check_main(input string tag);
        int vec, err, idx;
        logic [15:0] fy, fe;
        logic fin;
        model_eval(255, vec, err, idx, fy, fe);
        fin = (vec == EXP);
        chk({tag, ".vec"},   32'(vec_count), 32'(vec));
        chk({tag, ".err"},   32'(err_count), 32'(err));
        chk({tag, ".idx"},   32'(first_fail_idx), 32'(idx));
        chk({tag, ".ffy"},   32'(first_fail_y), 32'(fy));
        chk({tag, ".ffexp"}, 32'(first_fail_exp), 32'(fe));
        chk({tag, ".done"},  32'(done), 32'(fin));
        chk({tag, ".pass"},  32'(pass), 32'(fin && err == 0));
        chk({tag, ".ready"}, 32'(ready), 32'(!fin));
        chk({tag, ".busy"},  32'(busy), 32'(!fin));
    endtask

    task automatic start_run(input logic [1:0] o);
        start = 1'b1; op = o;
        step();
        start = 1'b0;
        acc.delete();
        m_op = o;
        check_main("start");
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] y);
        vec_t v;
        valid = 1'b1; a_in = a; b_in = b; y_in = y;
        step();
        valid = 1'b0;
        v.a = a; v.b = b; v.y = y;
        acc.push_back(v);
    endtask

    function automatic logic [15:0] rand_y(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] e;
        e = ref_gate(o, a, b);
        if ($urandom_range(0, 3) == 0) e = e ^ 16'($urandom_range(1, 65535));
        return e;
    endfunction

    initial begin
        logic [15:0] a, b;
        int k;
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; s_start = 1'b0; op = 2'b00;
        a_in = '0; b_in = '0; y_in = '0; valid = 1'b0; s_valid = 1'b0;
        m_op = 2'b00;

        #12;
        chk("rst.ready", 32'(ready), 0);
        chk("rst.busy",  32'(busy), 0);
        chk("rst.done",  32'(done), 0);
        chk("rst.vec",   32'(vec_count), 0);
        chk("rst.sat_done", 32'(s_done), 0);
        rst_n = 1'b1;
        step();
        chk("idle.ready", 32'(ready), 0);

        // Walking-ones NOT, all correct.
        start_run(2'b00);
        for (int i = 0; i < EXP; i++) begin
            a = (i == 0) ? 16'h0000 : 16'(1) << (i - 1);
            send(a, 16'($urandom), ~a);
            if (i == EXP - 2) check_main("walk.pre_last");
        end
        check_main("walk.end");
        chk("walk.pass_const", 32'(pass), 1);
        chk("walk.vec_const", 32'(vec_count), 17);
        valid = 1'b1;
        step();
        valid = 1'b0;
        check_main("walk.done_hold");

        // Fault on vector 5, restarted directly from DONE.
        start_run(2'b00);
        for (int i = 0; i < EXP; i++) begin
            a = (i == 0) ? 16'h0000 : 16'(1) << (i - 1);
            send(a, 16'($urandom), (i == 5) ? a : ~a);
        end
        check_main("fault");
        chk("fault.idx_const", 32'(first_fail_idx), 5);
        chk("fault.ffy_const", 32'(first_fail_y), 32'h0010);
        chk("fault.ffexp_const", 32'(first_fail_exp), 32'hFFEF);

        // Valid gaps with a mid-run start pulse and op change.
        start_run(2'b00);
        k = 0;
        while (acc.size() < EXP && k < 200) begin
            if (k == 2) begin start = 1'b1; op = 2'b11; end
            if (k % 4 == 0 || k % 4 == 3) begin
                a = 16'($urandom); b = 16'($urandom);
                send(a, b, rand_y(2'b00, a, b));
            end else begin
                valid = 1'b0;
                step();
            end
            start = 1'b0;
            check_main("gap");
            k++;
        end
        chk("gap.timeout", 32'(acc.size()), EXP);

        // XOR run restarted from DONE.
        start_run(2'b11);
        send(16'hFFFF, 16'h0F0F, 16'hF0F0);
        for (int i = 1; i < EXP; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            send(a, b, a ^ b);
        end
        check_main("xor");
        chk("xor.pass_const", 32'(pass), 1);

        // Async reset after 8 accepts, including an X observation.
        start_run(2'b01);
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            send(a, b, (i == 3) ? 16'hxxxx : rand_y(2'b01, a, b));
        end
        check_main("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("arst.ready", 32'(ready), 0);
        chk("arst.busy",  32'(busy), 0);
        chk("arst.vec",   32'(vec_count), 0);
        chk("arst.err",   32'(err_count), 0);
        chk("arst.ffy",   32'(first_fail_y), 0);
        chk("arst.done",  32'(done), 0);
        valid = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst.ready", 32'(ready), 0);
            chk("postrst.vec",   32'(vec_count), 0);
        end
        valid = 1'b0;

        // Saturation on the narrow-counter instance: every observation wrong.
        s_start = 1'b1; op = 2'b00;
        step();
        s_start = 1'b0;
        chk("sat.ready", 32'(s_ready), 1);
        acc.delete();
        m_op = 2'b00;
        for (int i = 0; i < S_EXP; i++) begin
            vec_t v;
            a = 16'($urandom);
            s_valid = 1'b1; a_in = a; b_in = 16'($urandom); y_in = a;
            step();
            v.a = a; v.b = b_in; v.y = a;
            acc.push_back(v);
        end
        s_valid = 1'b0;
        begin
            int vec, err, idx;
            logic [15:0] fy, fe;
            model_eval(15, vec, err, idx, fy, fe);
            chk("sat.vec",   32'(s_vec_count), 32'(vec));
            chk("sat.err",   32'(s_err_count), 32'(err));
            chk("sat.idx",   32'(s_first_fail_idx), 32'(idx));
            chk("sat.ffy",   32'(s_first_fail_y), 32'(fy));
            chk("sat.ffexp", 32'(s_first_fail_exp), 32'(fe));
        end
        chk("sat.err_const", 32'(s_err_count), 15);
        chk("sat.done",  32'(s_done), 1);
        chk("sat.pass",  32'(s_pass), 0);
        chk("sat.busy",  32'(s_busy), 0);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        chk("sat.hold_err", 32'(s_err_count), 15);
        chk("main.idle_vec", 32'(vec_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate16_resp_checker.md
Name: gate16_resp_checker

Overview:
- Synchronous self-checking response monitor for the 16-bit gate library (NOT/AND/OR/XOR).
- Takes a gate's operands and its observed output through a valid/ready handshake.
- Computes the expected result, compares, and accumulates pass/error statistics over a fixed-length run.
- Receiving end of the stimulus sequences the gate benches generate; used for on-chip and regression self-checking.

Parameters:
- WIDTH, 16, data width of operands and result.
- CNT_W, 8, width of vector/error counters and fail index.
- EXP_VECTORS, 17, vectors accepted per run; legal range 1..2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run (sampled in IDLE/DONE only).
- op  in  2  gate under check: 00 NOT a, 01 a AND b, 10 a OR b, 11 a XOR b; latched at start.
- a_in  in  WIDTH  operand a; vectors are declared [0:WIDTH-1], bit 0 is MSB.
- b_in  in  WIDTH  operand b (ignored for NOT).
- y_in  in  WIDTH  observed gate output.
- valid  in  1  a_in/b_in/y_in valid this cycle.
- ready  out  1  checker accepts a vector this cycle.
- busy  out  1  run in progress.
- done  out  1  run complete.
- pass  out  1  done and zero errors.
- vec_count  out  CNT_W  vectors accepted this run.
- err_count  out  CNT_W  mismatches this run, saturating.
- first_fail_idx  out  CNT_W  vec_count value at the first mismatch.
- first_fail_y  out  WIDTH  observed y at the first mismatch.
- first_fail_exp  out  WIDTH  expected y at the first mismatch.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, op latch=00, all outputs 0.
- All outputs are registered; ready and busy are decoded from registered state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=0, busy=0, done=0.
  - On start=1: go to RUN, latch op, clear vec_count, err_count and all first_fail_* fields.
- RUN:
  - ready=1, busy=1.
  - A vector is accepted on a rising edge with valid&ready=1.
  - expected = ~a_in / a_in&b_in / a_in|b_in / a_in^b_in, per latched op.
  - On accept: vec_count+=1.
  - If y_in != expected: err_count+=1, saturating at 2^CNT_W-1.
  - If this is the first mismatch: capture first_fail_idx = pre-increment vec_count, first_fail_y = y_in, first_fail_exp = expected.
  - valid=0 cycles change nothing.
  - start is ignored in RUN.
  - op changes after start are ignored.
- RUN -> DONE: on the edge that accepts the vector with vec_count==EXP_VECTORS-1.
  - On that same edge vec_count becomes EXP_VECTORS.
  - done and pass are visible the following cycle, with no extra latency.
- DONE:
  - ready=0, busy=0, done=1, pass=(err_count==0).
  - All counters and capture fields hold.
  - valid is ignored.
  - start=1 starts a new run: clears as in IDLE, goes to RUN, done drops the next cycle.
- X/Z on y_in counts as a mismatch (compare with !==).
- rst_n low mid-run aborts the run immediately; no partial results are retained.

Test Plan:
- Walking-ones NOT: start, op=00, 17 vectors (a=0x0000, 0x0001, 0x0002 … 0x8000) with y=~a -> done=1, pass=1, vec_count=17, err_count=0, ready=0.
- Fault injection: same run, but vector 5 (a=0x0010) sent with y=0x0010 -> err_count=1, pass=0, first_fail_idx=5, first_fail_y=0x0010, first_fail_exp=0xFFEF.
- Handshake gaps and ignored start: valid toggled 1,0,0,1 across run cycles, plus a start pulse and an op=11 change mid-RUN -> only valid-high cycles counted, op stays 00, run length unchanged.
- XOR and restart: after DONE, start with op=11, 17 vectors including a=0xFFFF, b=0x0F0F, y=0xF0F0 -> all counters cleared at restart, final pass=1.
- Async reset mid-run: rst_n=0 between edges after 8 accepts -> all outputs 0 immediately, state IDLE, ready=0, valid ignored until the next start.
- Saturation (CNT_W=4, EXP_VECTORS=15): every y wrong -> err_count=15 holds, vec_count=15, done=1, first_fail_idx=0.
